alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// alu_multicycle : 16-op unsigned ALU, single-cycle logic/add paths plus
//                  radix-2 shift-add multiply and restoring divide.
// Revision 1.0
// ============================================================================
module alu_multicycle #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  In_Valid_In,
  output logic                  In_Ready_Out,
  input  logic [3:0]            ALU_Operation_Select_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Out_Valid_Out,
  input  logic                  Out_Ready_In,
  output logic [DATA_WIDTH-1:0] Result_Out,
  output logic [DATA_WIDTH-1:0] Result_Hi_Out,
  output logic                  Carry_Out,
  output logic                  Zero_Out,
  output logic                  Negative_Out,
  output logic                  Overflow_Out,
  output logic                  Div_By_Zero_Out
);
  localparam int         c_W     = DATA_WIDTH;
  localparam int         c_CNT_W = $clog2(DATA_WIDTH);
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_MUL   = 2'd1;
  localparam logic [1:0] c_DIV   = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;
  localparam logic [3:0] c_OP_MUL = 4'h5;
  localparam logic [3:0] c_OP_DIV = 4'h6;
  localparam logic [3:0] c_OP_REM = 4'h7;
  localparam logic [c_W:0] c_ONE  = (c_W+1)'(1);

  logic [1:0]       state_q, state_d;
  logic             live_q;
  logic [3:0]       op_q;
  logic [c_W-1:0]   mcand_q, acc_q, lo_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic [c_W-1:0]   res_q, hi_q;
  logic             carry_q, zero_q, neg_q, ovf_q, dbz_q;

  logic             w_accept, w_is_mul, w_is_div, w_div0, w_last;
  logic [c_W:0]     w_a1, w_b1, w_mul_sum, w_div_shift;
  logic [c_W-1:0]   w_mul_acc_d, w_mul_lo_d, w_div_diff, w_div_acc_d, w_div_lo_d;
  logic             w_div_ge;
  logic [c_W:0]     w_imm_sum;
  logic [c_W-1:0]   w_imm_res;
  logic             w_imm_c, w_imm_v, w_imm_dbz;
  logic             w_fin_load, w_fin_c, w_fin_v, w_fin_dbz;
  logic [c_W-1:0]   w_fin_res, w_fin_hi;

  assign w_accept = In_Valid_In & In_Ready_Out;
  assign w_is_mul = (ALU_Operation_Select_In == c_OP_MUL);
  assign w_is_div = (ALU_Operation_Select_In == c_OP_DIV) | (ALU_Operation_Select_In == c_OP_REM);
  assign w_div0   = (Data_B_In == '0);
  assign w_last   = (cnt_q == '0);
  assign w_a1     = {1'b0, Data_A_In};
  assign w_b1     = {1'b0, Data_B_In};

  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) state_q <= c_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (w_accept) begin
        if (w_is_mul)                 state_d = c_MUL;
        else if (w_is_div && !w_div0) state_d = c_DIV;
        else                          state_d = c_DONE;
      end
      c_MUL:   if (w_last) state_d = c_DONE;
      c_DIV:   if (w_last) state_d = c_DONE;
      default: if (Out_Ready_In) state_d = c_IDLE;
    endcase
  end

  always_comb begin
    In_Ready_Out    = live_q && (state_q == c_IDLE);
    Out_Valid_Out   = (state_q == c_DONE);
    Result_Out      = res_q;
    Result_Hi_Out   = hi_q;
    Carry_Out       = carry_q;
    Zero_Out        = zero_q;
    Negative_Out    = neg_q;
    Overflow_Out    = ovf_q;
    Div_By_Zero_Out = dbz_q;
  end

  // Multiply: acc holds the running high word, lo shifts the multiplier out
  // as product bits shift in. Divide: acc is the partial remainder, lo shifts
  // the dividend out as quotient bits shift in.
  assign w_mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign w_mul_acc_d = w_mul_sum[c_W:1];
  assign w_mul_lo_d  = {w_mul_sum[0], lo_q[c_W-1:1]};
  assign w_div_shift = {acc_q, lo_q[c_W-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, mcand_q});
  assign w_div_diff  = w_div_shift[c_W-1:0] - mcand_q;
  assign w_div_acc_d = w_div_ge ? w_div_diff : w_div_shift[c_W-1:0];
  assign w_div_lo_d  = {lo_q[c_W-2:0], w_div_ge};

  always_comb begin
    w_imm_sum = '0;
    w_imm_res = '0;
    w_imm_c   = 1'b0;
    w_imm_v   = 1'b0;
    w_imm_dbz = 1'b0;
    case (ALU_Operation_Select_In)
      4'h0: begin
        w_imm_sum = w_a1 + c_ONE;
        w_imm_v   = ~Data_A_In[c_W-1] & w_imm_sum[c_W-1];
      end
      4'h1: begin
        w_imm_sum = w_a1 - c_ONE;
        w_imm_v   = Data_A_In[c_W-1] & ~w_imm_sum[c_W-1];
      end
      4'h2: begin
        w_imm_sum = w_a1 + w_b1;
        w_imm_v   = ~(Data_A_In[c_W-1] ^ Data_B_In[c_W-1]) & (w_imm_sum[c_W-1] ^ Data_A_In[c_W-1]);
      end
      4'h3: begin
        w_imm_sum = w_a1 - w_b1;
        w_imm_v   = (Data_A_In[c_W-1] ^ Data_B_In[c_W-1]) & (w_imm_sum[c_W-1] ^ Data_A_In[c_W-1]);
      end
      4'h4: begin
        w_imm_sum = w_b1 - w_a1;
        w_imm_v   = (Data_A_In[c_W-1] ^ Data_B_In[c_W-1]) & (w_imm_sum[c_W-1] ^ Data_B_In[c_W-1]);
      end
      4'h6: begin w_imm_res = '1;        w_imm_dbz = 1'b1; end
      4'h7: begin w_imm_res = Data_A_In; w_imm_dbz = 1'b1; end
      4'h8: w_imm_res = Data_A_In & Data_B_In;
      4'h9: w_imm_res = Data_A_In | Data_B_In;
      4'hA: w_imm_res = ~Data_A_In;
      4'hB: w_imm_res = ~Data_B_In;
      4'hC: w_imm_res = ~(Data_A_In & Data_B_In);
      4'hD: w_imm_res = ~(Data_A_In | Data_B_In);
      4'hE: w_imm_res = Data_A_In ^ Data_B_In;
      4'hF: w_imm_res = ~(Data_A_In ^ Data_B_In);
      default: ;
    endcase
    if (ALU_Operation_Select_In <= 4'h4) begin
      w_imm_res = w_imm_sum[c_W-1:0];
      w_imm_c   = w_imm_sum[c_W];
    end
  end

  always_comb begin
    w_fin_load = 1'b0;
    w_fin_res  = w_imm_res;
    w_fin_hi   = '0;
    w_fin_c    = w_imm_c;
    w_fin_v    = w_imm_v;
    w_fin_dbz  = w_imm_dbz;
    case (state_q)
      c_IDLE: w_fin_load = w_accept && (state_d == c_DONE);
      c_MUL: if (w_last) begin
        w_fin_load = 1'b1;
        w_fin_res  = w_mul_lo_d;
        w_fin_hi   = w_mul_acc_d;
        w_fin_c    = |w_mul_acc_d;
        w_fin_v    = 1'b0;
        w_fin_dbz  = 1'b0;
      end
      c_DIV: if (w_last) begin
        w_fin_load = 1'b1;
        w_fin_res  = (op_q == c_OP_REM) ? w_div_acc_d : w_div_lo_d;
        w_fin_c    = 1'b0;
        w_fin_v    = 1'b0;
        w_fin_dbz  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      live_q  <= 1'b0;
      op_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (w_accept) begin
        op_q    <= ALU_Operation_Select_In;
        mcand_q <= w_is_mul ? Data_A_In : Data_B_In;
        lo_q    <= w_is_mul ? Data_B_In : Data_A_In;
        acc_q   <= '0;
        cnt_q   <= c_CNT_W'(c_W - 1);
      end else if (state_q == c_MUL) begin
        acc_q <= w_mul_acc_d;
        lo_q  <= w_mul_lo_d;
        cnt_q <= cnt_q - c_CNT_W'(1);
      end else if (state_q == c_DIV) begin
        acc_q <= w_div_acc_d;
        lo_q  <= w_div_lo_d;
        cnt_q <= cnt_q - c_CNT_W'(1);
      end
      if (w_fin_load) begin
        res_q   <= w_fin_res;
        hi_q    <= w_fin_hi;
        carry_q <= w_fin_c;
        zero_q  <= (w_fin_res == '0);
        neg_q   <= w_fin_res[c_W-1];
        ovf_q   <= w_fin_v;
        dbz_q   <= w_fin_dbz;
      end
    end
  end
endmodule
`default_nettype wire
